// File: rtl/t84c_idu_pkg.sv
// Shared definitions for the block-transfer sequencer (LDI/LDD/LDIR/LDDR).
package t84c_idu_pkg;

    // Default width of the HL/DE/BC registers
    localparam int AW_DEF = 16;

    // Sequencer states: one RD/WR/STEP triple per transferred byte
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        STEP = 3'd3,
        FIN  = 3'd4
    } state_e;

endpackage

// File: rtl/idu_incdec.sv
// AW-bit +/-1 unit. Bit i toggles when every lower bit of the (optionally
// inverted) operand is 1; each carry is a parallel AND term rather than a ripple.
module idu_incdec
    import t84c_idu_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] value,
    input  logic          dec,
    output logic [AW-1:0] result
);

    logic [AW-1:0] t;
    logic [AW-1:0] c;

    // Decrement is increment on the inverted operand's carry pattern
    assign t    = dec ? ~value : value;
    assign c[0] = 1'b1;

    generate
        for (genvar i = 1; i < AW; i++) begin : g_cla
            assign c[i] = &t[i-1:0];
        end
    endgenerate

    // Wraps modulo 2^AW with no carry-out flag
    assign result = value ^ c;

endmodule

// File: rtl/idu_blkseq.sv
// Z80-style block transfer sequencer: reads (HL), writes (DE), steps HL/DE/BC.
// Optional macro T84C_BLK_REPEAT_EN enables LDIR/LDDR repeat; without it every
// start performs a single transfer and the repeat select is ignored.
// The repeat select port is named repeat_mode because "repeat" is a keyword.
module idu_blkseq
    import t84c_idu_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dir,
    input  logic          repeat_mode,
    input  logic [AW-1:0] hl_in,
    input  logic [AW-1:0] de_in,
    input  logic [AW-1:0] bc_in,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_ack,
    input  logic [7:0]    rd_data,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic          wr_ack,
    output logic [AW-1:0] hl,
    output logic [AW-1:0] de,
    output logic [AW-1:0] bc,
    output logic          busy,
    output logic          done,
    output logic          pv
);

    state_e        state_q, state_d;
    logic [AW-1:0] hl_q, hl_d, de_q, de_d, bc_q, bc_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          dir_q, dir_d;
    logic          pv_q, pv_d;
    logic [AW-1:0] hl_nx, de_nx, bc_nx;
    logic          again;

    idu_incdec #(.AW(AW)) u_hl (.value(hl_q), .dec(dir_q), .result(hl_nx));
    idu_incdec #(.AW(AW)) u_de (.value(de_q), .dec(dir_q), .result(de_nx));
    idu_incdec #(.AW(AW)) u_bc (.value(bc_q), .dec(1'b1),  .result(bc_nx));

`ifdef T84C_BLK_REPEAT_EN
    logic rep_q, rep_d;

    // Loop back only while the decremented count is nonzero
    assign again = rep_q && (bc_nx != '0);
`else
    logic unused_repeat;

    assign unused_repeat = repeat_mode;
    assign again         = 1'b0;
`endif

    // State and datapath registers; reset discards any transfer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hl_q    <= '0;
            de_q    <= '0;
            bc_q    <= '0;
            wdat_q  <= '0;
            dir_q   <= 1'b0;
            pv_q    <= 1'b0;
`ifdef T84C_BLK_REPEAT_EN
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hl_q    <= hl_d;
            de_q    <= de_d;
            bc_q    <= bc_d;
            wdat_q  <= wdat_d;
            dir_q   <= dir_d;
            pv_q    <= pv_d;
`ifdef T84C_BLK_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    // Next-state and register updates; acks only matter in their own state
    always_comb begin
        state_d = state_q;
        hl_d    = hl_q;
        de_d    = de_q;
        bc_d    = bc_q;
        wdat_d  = wdat_q;
        dir_d   = dir_q;
        pv_d    = pv_q;
`ifdef T84C_BLK_REPEAT_EN
        rep_d   = rep_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    hl_d    = hl_in;
                    de_d    = de_in;
                    bc_d    = bc_in;
                    dir_d   = dir;
`ifdef T84C_BLK_REPEAT_EN
                    rep_d   = repeat_mode;
`endif
                    state_d = RD;
                end
            end
            RD: begin
                if (rd_ack) begin
                    wdat_d  = rd_data;
                    state_d = WR;
                end
            end
            WR: begin
                if (wr_ack) state_d = STEP;
            end
            STEP: begin
                hl_d    = hl_nx;
                de_d    = de_nx;
                bc_d    = bc_nx;
                pv_d    = (bc_nx != '0);
                state_d = again ? RD : FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state, so RD/WR can never overlap
    assign rd_req  = (state_q == RD);
    assign wr_req  = (state_q == WR);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign rd_addr = hl_q;
    assign wr_addr = de_q;
    assign wr_data = wdat_q;
    assign hl      = hl_q;
    assign de      = de_q;
    assign bc      = bc_q;
    assign pv      = pv_q;

endmodule
